// File: rtl/prog_sequencer_pkg.sv
// Shared definitions for the program sequencer: FSM state encoding and default drain depth.
package prog_sequencer_pkg;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_EXEC  = 3'd2,
    S_DRAIN = 3'd3,
    S_DONE  = 3'd4
  } seq_state_t;

  localparam int DRAIN_CYCLES_DEFAULT = 2;

endpackage

// File: rtl/prog_sequencer.sv
// Program sequencer: walks instruction memory from address 0 for prog_len entries,
// issuing one decoded instruction every two cycles, then drains the datapath and pulses done.
module prog_sequencer
  import prog_sequencer_pkg::*;
#(
  parameter int INS_ADDR_WIDTH = 10,
  parameter int DRAIN_CYCLES   = DRAIN_CYCLES_DEFAULT
) (
  input  logic                      clk,
  input  logic                      rstn,
  input  logic                      start,
  input  logic                      abort,
  input  logic                      hold,
  input  logic [INS_ADDR_WIDTH:0]   prog_len,
  output logic [INS_ADDR_WIDTH-1:0] pc,
  output logic                      ins_fetch_en,
  output logic                      issue,
  output logic                      busy,
  output logic                      done,
  output logic [INS_ADDR_WIDTH:0]   ins_count
);

  localparam int DRAIN_EFF = (DRAIN_CYCLES < 1) ? 1 : DRAIN_CYCLES;
  localparam int DW        = $clog2(DRAIN_EFF + 1);
  localparam logic [INS_ADDR_WIDTH:0] MAX_LEN = {1'b1, {INS_ADDR_WIDTH{1'b0}}};
  localparam logic [INS_ADDR_WIDTH:0] ONE     = {{INS_ADDR_WIDTH{1'b0}}, 1'b1};

  seq_state_t              state_reg;
  seq_state_t              state_next;
  logic [INS_ADDR_WIDTH:0] len_q;
  logic [DW-1:0]           drain_cnt_reg;
  logic                    last_pc;

  // Length is clamped so the final pc is all-ones and never wraps.
  assign last_pc = ({1'b0, pc} == (len_q - ONE));

  always_comb begin
    state_next = state_reg;
    if (abort) begin
      state_next = S_IDLE;
    end else begin
      case (state_reg)
        S_IDLE:  if (start) state_next = (prog_len == '0) ? S_DONE : S_FETCH;
        S_FETCH: if (!hold) state_next = S_EXEC;
        S_EXEC:  state_next = last_pc ? S_DRAIN : S_FETCH;
        S_DRAIN: if (drain_cnt_reg == '0) state_next = S_DONE;
        S_DONE:  state_next = S_IDLE;
        default: state_next = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_reg     <= S_IDLE;
      len_q         <= '0;
      drain_cnt_reg <= '0;
      pc            <= '0;
      ins_count     <= '0;
      ins_fetch_en  <= 1'b0;
      issue         <= 1'b0;
      busy          <= 1'b0;
      done          <= 1'b0;
    end else begin
      state_reg    <= state_next;
      ins_fetch_en <= (state_next == S_FETCH);
      issue        <= (state_next == S_EXEC);
      busy         <= (state_next == S_FETCH) || (state_next == S_EXEC) || (state_next == S_DRAIN);
      done         <= (state_next == S_DONE);

      if (abort) begin
        pc <= '0;
      end else begin
        case (state_reg)
          S_IDLE: begin
            if (start) begin
              len_q     <= (prog_len > MAX_LEN) ? MAX_LEN : prog_len;
              pc        <= '0;
              ins_count <= '0;
            end
          end
          S_FETCH: begin
            // Count at the hand-off into EXEC so ins_count already includes the issuing instruction.
            if (!hold) ins_count <= ins_count + ONE;
          end
          S_EXEC: begin
            if (last_pc) drain_cnt_reg <= DW'(DRAIN_EFF - 1);
            else         pc            <= pc + 1'b1;
          end
          S_DRAIN: begin
            if (drain_cnt_reg != '0) drain_cnt_reg <= drain_cnt_reg - 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_prog_sequencer.sv
// Directed testbench for prog_sequencer: per-cycle traces of strobes compared with hand-derived masks.
module tb_prog_sequencer;
  import prog_sequencer_pkg::*;

  localparam int AW = 10;

  logic          clk = 1'b0;
  logic          rstn;
  logic          start;
  logic          abort;
  logic          hold;
  logic [AW:0]   prog_len;
  logic [AW-1:0] pc;
  logic          ins_fetch_en;
  logic          issue;
  logic          busy;
  logic          done;
  logic [AW:0]   ins_count;

  int n_checks = 0;
  int n_errors = 0;

  logic [63:0] hold_sched, abort_sched, rst_sched;
  logic [63:0] issue_m, busy_m, done_m, fetch_m;
  logic [AW-1:0] pc_at [0:63];
  int n_issue, first_done, last_issue_pc, pc_seq_err;

  prog_sequencer #(.INS_ADDR_WIDTH(AW), .DRAIN_CYCLES(2)) dut (
    .clk(clk), .rstn(rstn), .start(start), .abort(abort), .hold(hold),
    .prog_len(prog_len), .pc(pc), .ins_fetch_en(ins_fetch_en), .issue(issue),
    .busy(busy), .done(done), .ins_count(ins_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end else begin
      $display("ok   %s: 0x%0h", tag, got);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Start at edge 0, then observe cycles 1..ncyc; schedules apply inputs during cycle k.
  task automatic run_prog(input int len, input int ncyc);
    issue_m = '0; busy_m = '0; done_m = '0; fetch_m = '0;
    n_issue = 0; first_done = -1; last_issue_pc = -1; pc_seq_err = 0;
    for (int i = 0; i < 64; i++) pc_at[i] = '0;
    prog_len = (AW+1)'(len);
    start = 1'b1;
    step();
    start = 1'b0;
    prog_len = '0;
    for (int k = 1; k <= ncyc; k++) begin
      hold  = (k < 64) ? hold_sched[k]  : 1'b0;
      abort = (k < 64) ? abort_sched[k] : 1'b0;
      rstn  = (k < 64) ? ~rst_sched[k]  : 1'b1;
      if (k < 64) begin
        issue_m[k] = issue; busy_m[k] = busy; done_m[k] = done; fetch_m[k] = ins_fetch_en;
        pc_at[k] = pc;
      end
      if (issue) begin
        if (int'(pc) != n_issue) pc_seq_err++;
        n_issue++;
        last_issue_pc = int'(pc);
      end
      if (done && first_done < 0) first_done = k;
      step();
    end
    hold = 1'b0; abort = 1'b0; rstn = 1'b1;
    hold_sched = '0; abort_sched = '0; rst_sched = '0;
  endtask

  initial begin
    rstn = 1'b0; start = 1'b0; abort = 1'b0; hold = 1'b0; prog_len = '0;
    hold_sched = '0; abort_sched = '0; rst_sched = '0;
    step(); step();
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_issue_done_fetch", {61'd0, issue, done, ins_fetch_en}, 64'd0);
    check("rst_pc", 64'(pc), 64'd0);
    check("rst_count", 64'(ins_count), 64'd0);
    rstn = 1'b1;
    step();

    // prog_len=3, no hold
    run_prog(3, 12);
    check("s1_issue_mask", issue_m, 64'h54);
    check("s1_fetch_mask", fetch_m, 64'h2A);
    check("s1_busy_mask", busy_m, 64'h1FE);
    check("s1_done_mask", done_m, 64'h200);
    check("s1_pc_c2", 64'(pc_at[2]), 64'd0);
    check("s1_pc_c4", 64'(pc_at[4]), 64'd1);
    check("s1_pc_c6", 64'(pc_at[6]), 64'd2);
    check("s1_count", 64'(ins_count), 64'd3);

    // prog_len=2, hold during cycles 3-5
    hold_sched[3] = 1'b1; hold_sched[4] = 1'b1; hold_sched[5] = 1'b1;
    run_prog(2, 12);
    check("s2_issue_mask", issue_m, 64'h84);
    check("s2_done_mask", done_m, 64'h400);
    check("s2_pc_hold", {pc_at[3], pc_at[4], pc_at[5], pc_at[6]}, {10'd1, 10'd1, 10'd1, 10'd1});
    check("s2_count", 64'(ins_count), 64'd2);

    // prog_len=0
    run_prog(0, 4);
    check("s3_issue_mask", issue_m, 64'h0);
    check("s3_busy_mask", busy_m, 64'h0);
    check("s3_done_mask", done_m, 64'h2);

    // prog_len=5, abort during cycle 4
    abort_sched[4] = 1'b1;
    run_prog(5, 12);
    check("s4_issue_mask", issue_m, 64'h14);
    check("s4_busy_mask", busy_m, 64'h1E);
    check("s4_done_mask", done_m, 64'h0);
    check("s4_pc_after", 64'(pc_at[5]), 64'd0);
    check("s4_count", 64'(ins_count), 64'd2);

    // full address space, then an over-range length that must clamp
    for (int r = 0; r < 2; r++) begin
      run_prog((r == 0) ? 1024 : 1500, 2060);
      check(r == 0 ? "s5_n_issue" : "s5c_n_issue", 64'(n_issue), 64'd1024);
      check(r == 0 ? "s5_seq_err" : "s5c_seq_err", 64'(pc_seq_err), 64'd0);
      check(r == 0 ? "s5_last_pc" : "s5c_last_pc", 64'(last_issue_pc), 64'd1023);
      check(r == 0 ? "s5_done_cyc" : "s5c_done_cyc", 64'(first_done), 64'd2051);
      check(r == 0 ? "s5_count" : "s5c_count", 64'(ins_count), 64'd1024);
      check(r == 0 ? "s5_final_pc" : "s5c_final_pc", 64'(pc), 64'd1023);
    end

    // reset while draining, then clean restart
    rst_sched[3] = 1'b1;
    run_prog(1, 8);
    check("s6_issue_mask", issue_m, 64'h4);
    check("s6_busy_mask", busy_m, 64'hE);
    check("s6_done_mask", done_m, 64'h0);
    check("s6_count_rst", 64'(ins_count), 64'd0);
    run_prog(1, 8);
    check("s6b_issue_mask", issue_m, 64'h4);
    check("s6b_busy_mask", busy_m, 64'h1E);
    check("s6b_done_mask", done_m, 64'h20);
    check("s6b_count", 64'(ins_count), 64'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
